// File: rtl/cmd_initiator_sm_pkg.sv
// Shared types for the command initiator: FSM states, packet field positions
// and the error-flag bundle.
package cmd_initiator_sm_pkg;

  typedef enum logic [3:0] {
    IDLE, SEND_CSN, SEND_CC, SEND_CDC, SEND_DATA,
    WAIT_RSN, GET_RC, GET_RDC, GET_DATA, FLUSH, DONE
  } state_t;

  localparam int unsigned IDX_CSN  = 0;
  localparam int unsigned IDX_CC   = 1;
  localparam int unsigned IDX_CDC  = 2;
  localparam int unsigned IDX_DATA = 3;

  typedef struct packed {
    logic csn;
    logic len;
    logic timeout;
  } err_t;

endpackage

// File: rtl/cmd_initiator_sm_if.sv
// Stream bundle of the command initiator: start request, command data source,
// tx link, rx link and response data sink.
interface cmd_initiator_sm_if;
  logic        start;
  logic [31:0] cmd_code;
  logic [7:0]  cmd_count;

  logic        cd_tvalid;
  logic [31:0] cd_tdata;
  logic        cd_tready;

  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic        tx_tlast;
  logic        tx_tready;

  logic        rx_tvalid;
  logic [31:0] rx_tdata;
  logic        rx_tlast;
  logic        rx_tready;

  logic        rd_tvalid;
  logic [31:0] rd_tdata;
  logic        rd_tlast;
  logic        rd_tready;

  modport slave (
    input  start, cmd_code, cmd_count,
    input  cd_tvalid, cd_tdata, output cd_tready,
    output tx_tvalid, tx_tdata, tx_tlast, input tx_tready,
    input  rx_tvalid, rx_tdata, rx_tlast, output rx_tready,
    output rd_tvalid, rd_tdata, rd_tlast, input rd_tready
  );

  modport master (
    output start, cmd_code, cmd_count,
    output cd_tvalid, cd_tdata, input cd_tready,
    input  tx_tvalid, tx_tdata, tx_tlast, output tx_tready,
    output rx_tvalid, rx_tdata, rx_tlast, input rx_tready,
    input  rd_tvalid, rd_tdata, rd_tlast, output rd_tready
  );
endinterface

// File: rtl/cmd_timeout_ctr.sv
// Response timeout counter: cleared while disabled, flags the LIMIT-th
// enabled cycle.
module cmd_timeout_ctr #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign expire_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/cmd_initiator_sm.sv
// Command initiator: sends CSN/CC/CDC/data to the link, then parses the
// response header and forwards response data, flagging sequence/length/timeout errors.
module cmd_initiator_sm
  import cmd_initiator_sm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_CDC        = 255
) (
  input  logic               clk,
  input  logic               reset,
  cmd_initiator_sm_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic [31:0]        csn,
  output logic [31:0]        rsp_code,
  output logic [31:0]        rsp_count,
  output logic               err_csn,
  output logic               err_len,
  output logic               err_timeout
);
  localparam logic [7:0] MAX_CDC_W = 8'(MAX_CDC);

  state_t      state_q, state_d;
  logic [31:0] csn_q, cc_q, rc_q, rdc_q, rcnt_q;
  logic [7:0]  cdc_q;
  logic [8:0]  widx_q;
  logic        busy_q, done_q;
  err_t        err_q, err_set;
  logic        to_expire, tx_hs, rx_hs, tx_data_last, rd_last;
  logic [2:0][31:0] hdr;

  assign hdr[2'(IDX_CSN)] = csn_q;
  assign hdr[2'(IDX_CC)]  = cc_q;
  assign hdr[2'(IDX_CDC)] = {24'b0, cdc_q};

  assign tx_hs        = bus.tx_tvalid && bus.tx_tready;
  assign rx_hs        = bus.rx_tvalid && bus.rx_tready;
  // widx_q counts every tx word of the packet, so data word k sits at IDX_DATA+k-1
  assign tx_data_last = (widx_q == 9'(IDX_DATA) + {1'b0, cdc_q} - 9'd1);
  assign rd_last      = (rcnt_q + 32'd1 == rdc_q);

  cmd_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_to (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q != WAIT_RSN),
    .en_i     (state_q == WAIT_RSN),
    .expire_o (to_expire)
  );

  always_comb begin
    bus.cd_tready = 1'b0;
    bus.tx_tvalid = 1'b0;
    bus.tx_tdata  = '0;
    bus.tx_tlast  = 1'b0;
    bus.rx_tready = 1'b0;
    bus.rd_tvalid = 1'b0;
    bus.rd_tdata  = '0;
    bus.rd_tlast  = 1'b0;
    case (state_q)
      SEND_CSN: begin bus.tx_tvalid = 1'b1; bus.tx_tdata = hdr[2'(IDX_CSN)]; end
      SEND_CC:  begin bus.tx_tvalid = 1'b1; bus.tx_tdata = hdr[2'(IDX_CC)]; end
      SEND_CDC: begin
        bus.tx_tvalid = 1'b1;
        bus.tx_tdata  = hdr[2'(IDX_CDC)];
        bus.tx_tlast  = (cdc_q == 8'd0);
      end
      SEND_DATA: begin
        bus.tx_tvalid = bus.cd_tvalid;
        bus.tx_tdata  = bus.cd_tdata;
        bus.cd_tready = bus.tx_tready;
        bus.tx_tlast  = tx_data_last;
      end
      WAIT_RSN, GET_RC, GET_RDC, FLUSH: bus.rx_tready = 1'b1;
      GET_DATA: begin
        bus.rx_tready = bus.rd_tready;
        bus.rd_tvalid = bus.rx_tvalid;
        bus.rd_tdata  = bus.rx_tdata;
        bus.rd_tlast  = rd_last || bus.rx_tlast;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_set = '0;
    case (state_q)
      IDLE:      if (bus.start) state_d = SEND_CSN;
      SEND_CSN:  if (tx_hs) state_d = SEND_CC;
      SEND_CC:   if (tx_hs) state_d = SEND_CDC;
      SEND_CDC:  if (tx_hs) state_d = (cdc_q == 8'd0) ? WAIT_RSN : SEND_DATA;
      SEND_DATA: if (tx_hs && tx_data_last) state_d = WAIT_RSN;
      WAIT_RSN: begin
        if (rx_hs) begin
          if (bus.rx_tdata != csn_q) begin
            err_set.csn = 1'b1;
            state_d     = bus.rx_tlast ? DONE : FLUSH;
          end else if (bus.rx_tlast) begin
            err_set.len = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = GET_RC;
          end
        end else if (to_expire) begin
          err_set.timeout = 1'b1;
          state_d         = DONE;
        end
      end
      GET_RC: if (rx_hs) begin
        err_set.len = bus.rx_tlast;
        state_d     = bus.rx_tlast ? DONE : GET_RDC;
      end
      GET_RDC: if (rx_hs) begin
        if (bus.rx_tlast) begin
          err_set.len = (bus.rx_tdata != 32'd0);
          state_d     = DONE;
        end else if (bus.rx_tdata == 32'd0) begin
          err_set.len = 1'b1;
          state_d     = FLUSH;
        end else begin
          state_d = GET_DATA;
        end
      end
      GET_DATA: if (rx_hs) begin
        if (rd_last) begin
          err_set.len = !bus.rx_tlast;
          state_d     = bus.rx_tlast ? DONE : FLUSH;
        end else if (bus.rx_tlast) begin
          err_set.len = 1'b1;
          state_d     = DONE;
        end
      end
      FLUSH:   if (rx_hs && bus.rx_tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      csn_q   <= '0;
      cc_q    <= '0;
      cdc_q   <= '0;
      rc_q    <= '0;
      rdc_q   <= '0;
      rcnt_q  <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= err_q | err_set;
      if (state_q == IDLE && bus.start) begin
        cc_q   <= bus.cmd_code;
        cdc_q  <= (bus.cmd_count > MAX_CDC_W) ? MAX_CDC_W : bus.cmd_count;
        err_q  <= '0;
        widx_q <= '0;
      end
      if (tx_hs) widx_q <= widx_q + 9'd1;
      if (state_q == GET_RC && rx_hs) rc_q <= bus.rx_tdata;
      if (state_q == GET_RDC && rx_hs) begin
        rdc_q  <= bus.rx_tdata;
        rcnt_q <= '0;
      end
      if (state_q == GET_DATA && rx_hs) rcnt_q <= rcnt_q + 32'd1;
      if (state_q == DONE) csn_q <= csn_q + 32'd1;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign csn         = csn_q;
  assign rsp_code    = rc_q;
  assign rsp_count   = rdc_q;
  assign err_csn     = err_q.csn;
  assign err_len     = err_q.len;
  assign err_timeout = err_q.timeout;
endmodule

// File: tb/tb_cmd_initiator_sm.sv
// Scoreboard bench for cmd_initiator_sm: directed and random commands, expected
// packets derived from the packet rules, checked by a free-running monitor.
module tb_cmd_initiator_sm;
  import cmd_initiator_sm_pkg::*;

  localparam int TO = 16;
  localparam int K_GOOD = 0, K_BADCSN = 1, K_RCLAST = 2, K_RDC0X = 3,
                 K_EARLY = 4, K_LONG = 5, K_TO = 6;

  typedef struct {
    logic [31:0] csn, rc, rdc;
    logic        ecsn, elen, eto;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cmd_initiator_sm_if bus();
  logic        busy, done, err_csn, err_len, err_timeout;
  logic [31:0] csn, rsp_code, rsp_count;

  cmd_initiator_sm #(.TIMEOUT_CYCLES(TO), .MAX_CDC(255)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .done(done), .csn(csn), .rsp_code(rsp_code),
    .rsp_count(rsp_count), .err_csn(err_csn), .err_len(err_len),
    .err_timeout(err_timeout)
  );

  logic [32:0] tx_q[$];
  logic [32:0] rd_q[$];
  res_t        res_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, t_last_tx = 0, trdy_mode = 2;
  bit          mon_en = 1'b0;
  logic [31:0] m_csn = 0, m_rc = 0, m_rdc = 0;
  logic [32:0] mon_e;
  res_t        mon_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none (t=%0t)", nm, act, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (trdy_mode)
      0:       bus.tx_tready = 1'($urandom_range(0, 1));
      1:       bus.tx_tready = !bus.tx_tready;
      default: bus.tx_tready = 1'b1;
    endcase
    bus.rd_tready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) if (mon_en) begin
    if (bus.tx_tvalid && bus.tx_tready) begin
      if (tx_q.size() == 0) fail_now("tx_extra", 64'(bus.tx_tdata));
      else begin
        mon_e = tx_q.pop_front();
        chk("tx_word", 64'({bus.tx_tlast, bus.tx_tdata}), 64'(mon_e));
        if (mon_e[32]) t_last_tx = cyc;
      end
    end
    if (bus.rd_tvalid) begin
      if (rd_q.size() == 0) fail_now("rd_unexpected", 64'(bus.rd_tdata));
      else if (bus.rd_tready) begin
        mon_e = rd_q.pop_front();
        chk("rd_word", 64'({bus.rd_tlast, bus.rd_tdata}), 64'(mon_e));
      end
    end
    if (done) begin
      if (res_q.size() == 0) fail_now("done_extra", 64'(csn));
      else begin
        mon_r = res_q.pop_front();
        chk("err_csn", 64'(err_csn), 64'(mon_r.ecsn));
        chk("err_len", 64'(err_len), 64'(mon_r.elen));
        chk("err_timeout", 64'(err_timeout), 64'(mon_r.eto));
        chk("csn_used", 64'(csn), 64'(mon_r.csn));
        chk("rsp_code", 64'(rsp_code), 64'(mon_r.rc));
        chk("rsp_count", 64'(rsp_count), 64'(mon_r.rdc));
        chk("tx_words_left", 64'(tx_q.size()), 64'd0);
        chk("rd_words_left", 64'(rd_q.size()), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd1);
        if (mon_r.eto) chk("timeout_latency", 64'(cyc - t_last_tx), 64'(TO + 1));
      end
    end
  end

  task automatic drive_cd(input logic [31:0] d[$]);
    int g;
    foreach (d[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.cd_tvalid = 1'b1;
      bus.cd_tdata  = d[i];
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.cd_tready && g < 2000);
      if (!bus.cd_tready) begin fail_now("cd_stall", 64'(i)); bus.cd_tvalid = 1'b0; return; end
      @(posedge clk); #1;
      bus.cd_tvalid = 1'b0;
    end
  endtask

  task automatic drive_rx(input logic [31:0] w[$]);
    int g;
    foreach (w[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      bus.rx_tvalid = 1'b1;
      bus.rx_tdata  = w[i];
      bus.rx_tlast  = (i == w.size() - 1);
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.rx_tready && g < 2000);
      if (!bus.rx_tready) begin fail_now("rx_stall", 64'(i)); bus.rx_tvalid = 1'b0; return; end
      @(posedge clk); #1;
      bus.rx_tvalid = 1'b0;
      bus.rx_tlast  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 3000);
    if (!done) fail_now("done_missing", 64'(g));
  endtask

  task automatic start_while_busy();
    repeat (2) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.cmd_code = $urandom; bus.cmd_count = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] cc, input int cdc, input int kind,
                         input int p1, input int p2, input logic [31:0] rc);
    logic [31:0] d[$];
    logic [31:0] w[$];
    logic [31:0] pkt [0:300];
    res_t r;
    int n, nd, nfwd;
    for (int i = 0; i < cdc; i++) d.push_back($urandom);
    pkt[IDX_CSN] = m_csn;
    pkt[IDX_CC]  = cc;
    pkt[IDX_CDC] = 32'(cdc);
    for (int i = 0; i < cdc; i++) pkt[int'(IDX_DATA) + i] = d[i];
    n = int'(IDX_DATA) + cdc;
    for (int i = 0; i < n; i++) tx_q.push_back({(i == n - 1), pkt[i]});

    case (kind)
      K_GOOD:   begin w.push_back(m_csn); w.push_back(rc); w.push_back(32'(p1));
                      for (int i = 0; i < p1; i++) w.push_back($urandom); end
      K_BADCSN: begin w.push_back(m_csn + 32'd5);
                      for (int i = 1; i < p1; i++) w.push_back($urandom); end
      K_RCLAST: begin w.push_back(m_csn); w.push_back(rc); end
      K_RDC0X:  begin w.push_back(m_csn); w.push_back(rc); w.push_back(32'd0);
                      for (int i = 0; i < p1; i++) w.push_back($urandom); end
      K_EARLY:  begin w.push_back(m_csn); w.push_back(rc); w.push_back(32'(p1));
                      for (int i = 0; i < p2; i++) w.push_back($urandom); end
      K_LONG:   begin w.push_back(m_csn); w.push_back(rc); w.push_back(32'(p1));
                      for (int i = 0; i < p1 + p2; i++) w.push_back($urandom); end
      default: ;
    endcase

    r.csn = m_csn; r.ecsn = 1'b0; r.elen = 1'b0; r.eto = 1'b0;
    if (w.size() == 0) r.eto = 1'b1;
    else if (w[0] != m_csn) r.ecsn = 1'b1;
    else begin
      m_rc = w[1];
      if (w.size() == 2) r.elen = 1'b1;
      else begin
        m_rdc = w[2];
        nd = w.size() - 3;
        if (nd == 0) r.elen = (m_rdc != 0);
        else if (m_rdc == 0) r.elen = 1'b1;
        else begin
          nfwd = (nd < int'(m_rdc)) ? nd : int'(m_rdc);
          for (int i = 0; i < nfwd; i++) rd_q.push_back({(i == nfwd - 1), w[3 + i]});
          r.elen = (nd != int'(m_rdc));
        end
      end
    end
    r.rc = m_rc; r.rdc = m_rdc;
    res_q.push_back(r);
    m_csn = m_csn + 32'd1;

    bus.start = 1'b1; bus.cmd_code = cc; bus.cmd_count = 8'(cdc);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cmd_code = $urandom; bus.cmd_count = 8'($urandom);
    fork
      drive_cd(d);
      drive_rx(w);
      wait_done();
      start_while_busy();
    join
    @(posedge clk); #1;
    chk("csn_next", 64'(csn), 64'(m_csn));
    chk("idle_after_done", 64'({busy, done}), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p1, p2;
    bus.start = 1'b0; bus.cmd_code = '0; bus.cmd_count = '0;
    bus.cd_tvalid = 1'b0; bus.cd_tdata = '0;
    bus.rx_tvalid = 1'b0; bus.rx_tdata = '0; bus.rx_tlast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_csn", 64'(csn), 64'd0);
    chk("rst_streams", 64'({bus.tx_tvalid, bus.cd_tready, bus.rx_tready, bus.rd_tvalid}), 64'd0);
    chk("rst_errs", 64'({err_csn, err_len, err_timeout}), 64'd0);
    chk("rst_rsp", 64'({rsp_code, rsp_count}), 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_cmd(32'h10, 0, K_GOOD, 0, 0, 32'h10);
    trdy_mode = 1;
    run_cmd($urandom, 3, K_GOOD, 1, 0, $urandom);
    trdy_mode = 2;
    run_cmd($urandom, 1, K_BADCSN, 4, 0, 0);
    run_cmd($urandom, 2, K_EARLY, 4, 2, $urandom);
    run_cmd($urandom, 0, K_TO, 0, 0, 0);
    run_cmd($urandom, 1, K_RCLAST, 0, 0, $urandom);
    run_cmd($urandom, 0, K_RDC0X, 2, 0, $urandom);
    run_cmd($urandom, 2, K_LONG, 2, 1, $urandom);

    trdy_mode = 0;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 6);
      p1 = 0; p2 = 0;
      case (k)
        K_GOOD:   p1 = $urandom_range(0, 4);
        K_BADCSN: p1 = $urandom_range(1, 4);
        K_RDC0X:  p1 = $urandom_range(1, 3);
        K_EARLY:  begin p1 = $urandom_range(2, 5); p2 = $urandom_range(1, p1 - 1); end
        K_LONG:   begin p1 = $urandom_range(1, 3); p2 = $urandom_range(1, 2); end
        default: ;
      endcase
      run_cmd($urandom, $urandom_range(0, 5), k, p1, p2, $urandom);
    end

    // reset in the middle of SEND_DATA
    trdy_mode = 2;
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cmd_code = $urandom; bus.cmd_count = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.cd_tvalid = 1'b1; bus.cd_tdata = $urandom;
    chk("pre_rst_cd_tready", 64'(bus.cd_tready), 64'd1);
    @(posedge clk); #1;
    chk("pre_rst_csn_nonzero", 64'(csn != 32'd0), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_csn", 64'(csn), 64'd0);
    chk("mid_rst_streams", 64'({bus.tx_tvalid, bus.cd_tready, bus.rx_tready, bus.rd_tvalid}), 64'd0);
    chk("mid_rst_flags", 64'({done, err_csn, err_len, err_timeout}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.cd_tvalid = 1'b0;
    tx_q.delete(); rd_q.delete(); res_q.delete();
    m_csn = 0; m_rc = 0; m_rdc = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_cmd($urandom, 2, K_GOOD, 2, 0, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmd_initiator_sm.md
CMD_INITIATOR_SM -- requirements
Module: cmd_initiator_sm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning max cycles to wait for the first response word.
REQ-002 SHALL have parameter MAX_CDC, default 255, meaning max command data words; cmd_count width is 8.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 start  in  1  one-cycle request to issue a command; honoured only in IDLE.
REQ-006 cmd_code  in  32  CC, sampled on start.
REQ-007 cmd_count  in  8  CDC, sampled on start.
REQ-008 cd_tvalid / cd_tdata[31:0] / cd_tready  in/in/out  command data source.
REQ-009 tx_tvalid / tx_tdata[31:0] / tx_tlast / tx_tready  out/out/out/in  command packet to link.
REQ-010 rx_tvalid / rx_tdata[31:0] / rx_tlast / rx_tready  in/in/in/out  response packet from link.
REQ-011 rd_tvalid / rd_tdata[31:0] / rd_tlast / rd_tready  out/out/out/in  response data to consumer.
REQ-012 busy, done  out  1  busy is high outside IDLE; done is a one-cycle pulse.
REQ-013 csn, rsp_code, rsp_count  out  32/32/32  CSN used, captured RC, captured RDC.
REQ-014 err_csn, err_len, err_timeout  out  1 each  error flags, valid from done until next start.

Function
REQ-015 Every transfer SHALL occur only on a cycle with valid and ready both high.
REQ-016 States SHALL be IDLE, SEND_CSN, SEND_CC, SEND_CDC, SEND_DATA, WAIT_RSN, GET_RC, GET_RDC, GET_DATA, FLUSH, DONE.
REQ-017 IDLE->SEND_CSN on start; start SHALL also latch cmd_code and cmd_count and clear all error flags.
REQ-018 SEND_CSN/SEND_CC/SEND_CDC SHALL drive csn, CC and zero-extended CDC in turn, each held with tx_tvalid high until accepted.
REQ-019 tx_tlast SHALL be high on the CDC word when CDC=0, otherwise on data word number CDC.
REQ-020 In SEND_DATA, tx_tdata=cd_tdata, tx_tvalid=cd_tvalid and cd_tready=tx_tready, combinationally; a counter SHALL count accepted words and exit to WAIT_RSN after CDC words.
REQ-021 In WAIT_RSN, rx_tready SHALL be high and a timeout counter, cleared on entry, SHALL increment each cycle; reaching TIMEOUT_CYCLES SHALL set err_timeout and go to DONE.
REQ-022 If RSN != csn, the machine SHALL set err_csn and go to FLUSH, or to DONE when that word has rx_tlast.
REQ-023 GET_RC and GET_RDC SHALL capture rsp_code and rsp_count; rx_tlast on RC, or on RDC with RDC!=0, SHALL set err_len and go to DONE.
REQ-024 RDC=0 SHALL require rx_tlast on the RDC word; if it is absent, the machine SHALL set err_len and go to FLUSH.
REQ-025 In GET_DATA, rd_tdata=rx_tdata, rd_tvalid=rx_tvalid and rx_tready=rd_tready; rd_tlast SHALL be high on data word RDC.
REQ-026 Early rx_tlast SHALL set err_len, forward the word with rd_tlast high, and go to DONE.
REQ-027 A missing rx_tlast on word RDC SHALL set err_len and go to FLUSH.
REQ-028 FLUSH SHALL hold rx_tready high, discard words until one with rx_tlast, then go to DONE.
REQ-029 DONE SHALL pulse done for one cycle, increment csn by 1 (wrapping 0xFFFFFFFF->0) and return to IDLE.
REQ-030 rx words arriving outside WAIT_RSN..FLUSH SHALL NOT be consumed; rx_tready SHALL be low.
REQ-031 start outside IDLE SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE and set every output, csn and all counters to 0, regardless of any packet in progress; no partial packet is resumed.

Structure
REQ-033 A shared package SHALL hold the state enumeration and the packet field indices (CSN=0, CC=1, CDC=2, first data=3).
REQ-034 The block SHALL be a single module; the timeout counter MAY be a sub-module named cmd_timeout_ctr.

Verification
REQ-035 start, CC=0x10, CDC=0 with tx_tready=1 -> tx words 0,0x10,0 with tlast on the third; response 0,0x10,0 with tlast -> done, no errors, csn=1.
REQ-036 CDC=3, data A,B,C with tx_tready toggling 1010 -> words 0,CC,3,A,B,C, tlast only on C, none lost or duplicated.
REQ-037 Response RSN=5 against csn=0, 4 words, tlast on the 4th -> err_csn=1, 4 words flushed, rd_tvalid never high.
REQ-038 Response RDC=4 with tlast on data word 2 -> err_len=1, rd_tlast on word 2, done.
REQ-039 No response, TIMEOUT_CYCLES=16 -> err_timeout after 16 cycles in WAIT_RSN, done pulse.
REQ-040 reset asserted during SEND_DATA -> all outputs 0 immediately, IDLE, next start sends csn=0.
